// File: rtl/switch_debounce_fsm_pkg.sv
// Shared state encoding and default timing constants for the push-button debouncer.
package switch_debounce_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE         = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } state_t;

    // 10 ms debounce and 1 s long press at a 25 MHz clock
    localparam int DEFAULT_DEBOUNCE_LIMIT   = 250000;
    localparam int DEFAULT_LONG_PRESS_LIMIT = 25000000;
    localparam int DEFAULT_ACTIVE_LEVEL     = 1;

endpackage

// File: rtl/switch_debounce_fsm_sync_2ff.sv
// Two-flop synchroniser for an asynchronous pin, with a selectable reset level.
module sync_2ff
    import switch_debounce_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_D,
    output logic o_Q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_D;
            r_sync <= r_meta;
        end
    end

    assign o_Q = r_sync;

endmodule

// File: rtl/switch_debounce_fsm.sv
// Debounces a raw push-button into a clean level plus press/release/long-press strobes.
// Defining SWITCH_DEBOUNCE_TOGGLE_EN adds an o_Toggle output that flips on every press.
module switch_debounce_fsm
    import switch_debounce_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT   = DEFAULT_DEBOUNCE_LIMIT,
    parameter int LONG_PRESS_LIMIT = DEFAULT_LONG_PRESS_LIMIT,
    parameter int ACTIVE_LEVEL     = DEFAULT_ACTIVE_LEVEL
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Press_Pulse,
    output logic o_Release_Pulse,
    output logic o_Long_Press
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
    ,
    output logic o_Toggle
`endif
);

    localparam int DEB_W  = $clog2(DEBOUNCE_LIMIT) + 1;
    localparam int LONG_W = $clog2(LONG_PRESS_LIMIT) + 1;
    localparam logic [DEB_W-1:0]  DEB_LAST     = DEB_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [LONG_W-1:0] LONG_MAX     = LONG_W'(LONG_PRESS_LIMIT);
    localparam logic              RELEASED_LVL = (ACTIVE_LEVEL != 0) ? 1'b0 : 1'b1;

    logic              w_sync;
    logic              w_s_in;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [DEB_W-1:0]  r_deb_cnt;
    logic [DEB_W-1:0]  w_deb_nxt;
    logic [DEB_W-1:0]  w_deb_inc;
    logic [LONG_W-1:0] r_long_cnt;
    logic [LONG_W-1:0] w_long_nxt;
    logic [LONG_W-1:0] w_long_inc;
    logic              r_switch;
    logic              w_switch_nxt;
    logic              r_press;
    logic              w_press_nxt;
    logic              r_release;
    logic              w_release_nxt;
    logic              r_long;
    logic              w_long_nxt_pulse;
    logic              r_long_fired;
    logic              w_long_fired_nxt;

    sync_2ff #(
        .RESET_VAL (RELEASED_LVL)
    ) u_sync (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_D     (i_Switch),
        .o_Q     (w_sync)
    );

    // After this, 1 always means pressed regardless of button wiring
    assign w_s_in     = w_sync ^ RELEASED_LVL;
    assign w_deb_inc  = r_deb_cnt + 1'b1;
    assign w_long_inc = r_long_cnt + 1'b1;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state      <= IDLE;
            r_deb_cnt    <= '0;
            r_long_cnt   <= '0;
            r_switch     <= 1'b0;
            r_press      <= 1'b0;
            r_release    <= 1'b0;
            r_long       <= 1'b0;
            r_long_fired <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_deb_cnt    <= w_deb_nxt;
            r_long_cnt   <= w_long_nxt;
            r_switch     <= w_switch_nxt;
            r_press      <= w_press_nxt;
            r_release    <= w_release_nxt;
            r_long       <= w_long_nxt_pulse;
            r_long_fired <= w_long_fired_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_deb_nxt        = r_deb_cnt;
        w_switch_nxt     = r_switch;
        w_press_nxt      = 1'b0;
        w_release_nxt    = 1'b0;
        w_long_nxt_pulse = 1'b0;
        w_long_fired_nxt = r_long_fired;
        w_long_nxt       = r_long_cnt;

        // Entering a PEND state already counts as the first stable cycle
        case (r_state)
            IDLE: begin
                if (w_s_in) begin
                    w_state_nxt = PRESS_PEND;
                    w_deb_nxt   = '0;
                end
            end
            PRESS_PEND: begin
                if (!w_s_in) begin
                    w_state_nxt = IDLE;
                    w_deb_nxt   = '0;
                end else if (w_deb_inc == DEB_LAST) begin
                    w_state_nxt  = PRESSED;
                    w_deb_nxt    = '0;
                    w_switch_nxt = 1'b1;
                    w_press_nxt  = 1'b1;
                end else begin
                    w_deb_nxt = w_deb_inc;
                end
            end
            PRESSED: begin
                if (!w_s_in) begin
                    w_state_nxt = RELEASE_PEND;
                    w_deb_nxt   = '0;
                end
            end
            RELEASE_PEND: begin
                if (w_s_in) begin
                    w_state_nxt = PRESSED;
                    w_deb_nxt   = '0;
                end else if (w_deb_inc == DEB_LAST) begin
                    w_state_nxt      = IDLE;
                    w_deb_nxt        = '0;
                    w_switch_nxt     = 1'b0;
                    w_release_nxt    = 1'b1;
                    w_long_fired_nxt = 1'b0;
                end else begin
                    w_deb_nxt = w_deb_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_deb_nxt   = '0;
            end
        endcase

        // A release qualifying on the same edge suppresses the long-press strobe
        if (w_press_nxt) begin
            w_long_nxt = '0;
        end else if (r_switch && (r_long_cnt != LONG_MAX)) begin
            w_long_nxt = w_long_inc;
            if ((w_long_inc == LONG_MAX) && !r_long_fired && !w_release_nxt) begin
                w_long_nxt_pulse = 1'b1;
                w_long_fired_nxt = 1'b1;
            end
        end
    end

    assign o_Switch        = r_switch;
    assign o_Press_Pulse   = r_press;
    assign o_Release_Pulse = r_release;
    assign o_Long_Press    = r_long;

`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
    logic r_toggle;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_toggle <= 1'b0;
        end else if (w_press_nxt) begin
            r_toggle <= ~r_toggle;
        end
    end

    assign o_Toggle = r_toggle;
`endif

endmodule

// File: tb/tb_switch_debounce_fsm.sv
// Bench for switch_debounce_fsm: vector tables, hand-written corner sequences and random bouncing.
module tb_switch_debounce_fsm;

    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic i_Clk;
    logic i_Rst_L;
    logic i_Switch;
    logic o_Switch;
    logic o_Press_Pulse;
    logic o_Release_Pulse;
    logic o_Long_Press;
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
    logic o_Toggle;
`endif

    switch_debounce_fsm #(
        .DEBOUNCE_LIMIT   (DEB),
        .LONG_PRESS_LIMIT (LONG),
        .ACTIVE_LEVEL     (1)
    ) dut (
        .i_Clk           (i_Clk),
        .i_Rst_L         (i_Rst_L),
        .i_Switch        (i_Switch),
        .o_Switch        (o_Switch),
        .o_Press_Pulse   (o_Press_Pulse),
        .o_Release_Pulse (o_Release_Pulse),
        .o_Long_Press    (o_Long_Press)
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
        ,
        .o_Toggle        (o_Toggle)
`endif
    );

    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    typedef struct {
        logic pin;
        logic sw;
        logic pr;
        logic rl;
        logic lp;
    } vec_t;

    vec_t vecs[$];

    int n_vec;
    int n_err;
    int cyc;
    int long_seen;
    int long_last;

    // Reference model: run-length of synchronised samples that differ from the accepted level
    logic m_hist0, m_hist1;
    logic m_level;
    int   m_run;
    int   m_hold;
    logic m_fired;
    logic m_press, m_rel, m_long;
    logic m_tog;

    task automatic model_reset();
        m_hist0 = 1'b0; m_hist1 = 1'b0;
        m_level = 1'b0; m_run = 0; m_hold = 0; m_fired = 1'b0;
        m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0; m_tog = 1'b0;
    endtask

    task automatic model_step(input logic pin_v);
        logic s;
        logic old_level;
        logic releasing;
        m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
        if (!i_Rst_L) begin
            model_reset();
            return;
        end
        s = m_hist1;
        m_hist1 = m_hist0;
        m_hist0 = pin_v;
        old_level = m_level;
        releasing = 1'b0;
        if (s != m_level) begin
            m_run++;
            if (m_run == DEB) begin
                m_run = 0;
                m_level = s;
                if (s) begin
                    m_press = 1'b1; m_hold = 0; m_tog = ~m_tog;
                end else begin
                    m_rel = 1'b1; m_fired = 1'b0; releasing = 1'b1;
                end
            end
        end else begin
            m_run = 0;
        end
        if (old_level && (m_hold < LONG)) begin
            m_hold++;
            if ((m_hold == LONG) && !m_fired && !releasing) begin
                m_long = 1'b1; m_fired = 1'b1;
            end
        end
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive pin at the falling edge, clock once, compare against the model at the next falling edge
    task automatic cycle(input logic pin_v);
        i_Switch = pin_v;
        @(posedge i_Clk);
        model_step(pin_v);
        @(negedge i_Clk);
        cyc++;
        check("sw", o_Switch, m_level);
        check("press", o_Press_Pulse, m_press);
        check("release", o_Release_Pulse, m_rel);
        check("long", o_Long_Press, m_long);
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
        check("toggle", o_Toggle, m_tog);
`endif
        if (o_Long_Press === 1'b1) begin
            long_seen++;
            long_last = cyc;
        end
    endtask

    task automatic wait_edge(input logic pin_v, output int n);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle(pin_v);
            if ((pin_v && o_Press_Pulse === 1'b1) || (!pin_v && o_Release_Pulse === 1'b1)) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0);
    endtask

    task automatic apply_reset();
        i_Rst_L = 1'b0;
        #1;
        model_reset();
        cycle(1'b0);
        cycle(1'b0);
        i_Rst_L = 1'b1;
    endtask

    task automatic add(input logic p, input logic s, input logic pr, input logic rl, input int n);
        vec_t v;
        v.pin = p; v.sw = s; v.pr = pr; v.rl = rl; v.lp = 1'b0;
        repeat (n) vecs.push_back(v);
    endtask

    initial begin
        int n;
        int rise;
        n_vec = 0; n_err = 0; cyc = 0; long_seen = 0; long_last = 0;

        // Clean short press: pin high 8 cycles, then low
        add(1, 0, 0, 0, 5); add(1, 1, 1, 0, 1); add(1, 1, 0, 0, 2);
        add(0, 1, 0, 0, 5); add(0, 0, 0, 1, 1); add(0, 0, 0, 0, 2);
        // Bounce 1,1,0,1,1,1,1 then hold, then release
        add(1, 0, 0, 0, 2); add(0, 0, 0, 0, 1); add(1, 0, 0, 0, 5);
        add(1, 1, 1, 0, 1); add(1, 1, 0, 0, 1);
        add(0, 1, 0, 0, 5); add(0, 0, 0, 1, 1); add(0, 0, 0, 0, 2);

        i_Rst_L = 1'b0;
        i_Switch = 1'b0;
        model_reset();
        repeat (2) @(negedge i_Clk);
        check("rst_sw", o_Switch, 1'b0);
        check("rst_press", o_Press_Pulse, 1'b0);
        check("rst_release", o_Release_Pulse, 1'b0);
        check("rst_long", o_Long_Press, 1'b0);
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
        check("rst_toggle", o_Toggle, 1'b0);
`endif
        i_Rst_L = 1'b1;
        idle(4);

        foreach (vecs[i]) begin
            cycle(vecs[i].pin);
            check("tbl_sw", o_Switch, vecs[i].sw);
            check("tbl_press", o_Press_Pulse, vecs[i].pr);
            check("tbl_release", o_Release_Pulse, vecs[i].rl);
            check("tbl_long", o_Long_Press, vecs[i].lp);
        end

        // Long press: one strobe 20 cycles after the rise, release 6 cycles after the pin falls
        idle(4);
        long_seen = 0;
        wait_edge(1'b1, n);
        check_int("long_press_latency", n, 6);
        rise = cyc;
        repeat (30) cycle(1'b1);
        check_int("long_count", long_seen, 1);
        check_int("long_offset", long_last - rise, LONG);
        wait_edge(1'b0, n);
        check_int("long_release_latency", n, 6);

        // Release qualifying on the same edge as the long limit: release wins
        idle(4);
        long_seen = 0;
        wait_edge(1'b1, n);
        check_int("tie_press_latency", n, 6);
        repeat (14) cycle(1'b1);
        wait_edge(1'b0, n);
        check_int("tie_release_latency", n, 6);
        check_int("tie_long_count", long_seen, 0);

        // One cycle more held: long fires just before the release
        idle(4);
        long_seen = 0;
        wait_edge(1'b1, n);
        rise = cyc;
        repeat (15) cycle(1'b1);
        wait_edge(1'b0, n);
        check_int("late_release_latency", n, 6);
        check_int("late_long_count", long_seen, 1);
        check_int("late_long_offset", long_last - rise, LONG);

        // Asynchronous reset while pressed, then a still-held button counts as a fresh press
        idle(4);
        wait_edge(1'b1, n);
        repeat (3) cycle(1'b1);
        check("pre_rst_sw", o_Switch, 1'b1);
        i_Rst_L = 1'b0;
        #1;
        model_reset();
        check("midrst_sw", o_Switch, 1'b0);
        check("midrst_release", o_Release_Pulse, 1'b0);
        cycle(1'b1);
        cycle(1'b1);
        i_Rst_L = 1'b1;
        wait_edge(1'b1, n);
        check_int("post_rst_press_latency", n, 6);
        wait_edge(1'b0, n);
        check_int("post_rst_release_latency", n, 6);

        // Random bouncing runs checked cycle by cycle against the model
        for (int r = 0; r < 160; r++) begin
            logic pin_r;
            int   len;
            pin_r = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40))
                                               : int'($urandom_range(1, 6));
            repeat (len) cycle(pin_r);
        end

`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
        apply_reset();
        idle(4);
        check("toggle_start", o_Toggle, 1'b0);
        for (int p = 0; p < 3; p++) begin
            wait_edge(1'b1, n);
            check_int("toggle_press_latency", n, 6);
            check("toggle_seq", o_Toggle, (p % 2 == 0) ? 1'b1 : 1'b0);
            wait_edge(1'b0, n);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
